// File: rtl/dff_share_arb.sv
// Round-robin write arbiter sharing one WIDTH-bit register among N_REQ requesters.
// Grants one owner at a time, with optional locked bursts of up to MAX_BURST words.
`timescale 1ns/1ps
module dff_share_arb #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ*WIDTH-1:0] data,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic [2:0]             q_owner,
    output logic                   busy
);

    localparam int unsigned IdxW = $clog2(N_REQ);

    typedef logic [IdxW-1:0] idx_t;
    typedef enum logic [1:0] {StIdle, StWrite, StAck} state_e;

    state_e     state_q;
    idx_t       owner_q;
    idx_t       ptr_q;
    idx_t       q_owner_q;
    logic [7:0] burst_cnt_q;
    logic       cont_q;

    logic [WIDTH-1:0] words [N_REQ];
    logic             found;
    idx_t             winner;
    idx_t             cand;
    idx_t             ptr_next;

    function automatic logic [N_REQ-1:0] onehot(input idx_t i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            words[i] = data[i*WIDTH +: WIDTH];
        end
    end

    // First requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = idx_t'((int'(ptr_q) + k) % int'(N_REQ));
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign ptr_next = (owner_q == idx_t'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            ptr_q       <= '0;
            q_owner_q   <= '0;
            burst_cnt_q <= '0;
            cont_q      <= 1'b0;
            gnt         <= '0;
            ack         <= '0;
            q           <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        owner_q     <= winner;
                        gnt         <= onehot(winner);
                        burst_cnt_q <= 8'd1;
                        state_q     <= StWrite;
                    end
                end
                StWrite: begin
                    q         <= words[owner_q];
                    q_owner_q <= owner_q;
                    ack       <= onehot(owner_q);
                    cont_q    <= lock[owner_q] && (burst_cnt_q < 8'(MAX_BURST));
                    state_q   <= StAck;
                end
                StAck: begin
                    ack <= '0;
                    if (cont_q) begin
                        burst_cnt_q <= burst_cnt_q + 8'd1;
                        state_q     <= StWrite;
                    end else begin
                        gnt     <= '0;
                        ptr_q   <= ptr_next;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign q_owner = 3'(q_owner_q);
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_dff_share_arb.sv
// Scoreboard bench for dff_share_arb: stimulus queues expected acks (cycle, owner, word),
// a negedge monitor pops and compares each ack pulse.
`timescale 1ns/1ps
module tb_dff_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic [2:0]  q_owner;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [3:0] ack;
        logic [7:0] q;
        logic [2:0] owner;
    } exp_t;

    exp_t sb[$];

    dff_share_arb #(
        .N_REQ    (4),
        .WIDTH    (8),
        .MAX_BURST(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .lock   (lock),
        .data   (data),
        .gnt    (gnt),
        .ack    (ack),
        .q      (q),
        .q_owner(q_owner),
        .busy   (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int own, input logic [7:0] v);
        exp_t e;
        e.cyc   = c;
        e.ack   = 4'b0001 << own;
        e.q     = v;
        e.owner = 3'(own);
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_word(input int i, input logic [7:0] v);
        data[i*8 +: 8] = v;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        tick(1);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_q", 32'(q), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick(1);
    endtask

    // Monitor: every ack pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0 && ack !== 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(ack), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_cycle", 32'(cyc), 32'(e.cyc));
                check("ack_vec", 32'(ack), 32'(e.ack));
                check("q_word", 32'(q), 32'(e.q));
                check("q_owner", 32'(q_owner), 32'(e.owner));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        data = '0;
        tick(2);
        check("init_gnt", 32'(gnt), 0);
        check("init_ack", 32'(ack), 0);
        check("init_q", 32'(q), 0);
        check("init_owner", 32'(q_owner), 0);
        check("init_busy", 32'(busy), 0);
        rst = 1'b0;
        tick(1);

        // Reset mid-WRITE: word is discarded without ack.
        req = 4'b0010;
        set_word(1, 8'h77);
        tick(1);
        check("midw_gnt", 32'(gnt), 32'h2);
        check("midw_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("midw_rst_gnt", 32'(gnt), 0);
        check("midw_rst_busy", 32'(busy), 0);
        check("midw_rst_q", 32'(q), 0);
        tick(1);
        rst = 1'b0;
        req = '0;
        tick(4);

        // Single write from requester 2.
        c0  = cyc;
        req = 4'b0100;
        set_word(2, 8'hA5);
        push(c0 + 2, 2, 8'hA5);
        tick(1);
        check("single_gnt", 32'(gnt), 32'h4);
        check("single_ack_early", 32'(ack), 0);
        tick(1);
        req = '0;
        tick(1);
        check("single_idle_busy", 32'(busy), 0);
        check("single_idle_gnt", 32'(gnt), 0);
        check("single_q_hold", 32'(q), 32'hA5);

        // Round robin with all four requesting.
        do_reset();
        c0  = cyc;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) set_word(i, 8'(8'h10 + i));
        for (int k = 0; k < 5; k++) push(c0 + 2 + 3 * k, k % 4, 8'(8'h10 + (k % 4)));
        tick(14);
        req = '0;
        tick(3);
        check("rr_busy", 32'(busy), 0);

        // Locked burst hits MAX_BURST while requester 3 waits.
        do_reset();
        c0   = cyc;
        req  = 4'b1010;
        lock = 4'b0010;
        set_word(1, 8'h01);
        set_word(3, 8'h33);
        push(c0 + 2, 1, 8'h01);
        push(c0 + 4, 1, 8'h02);
        push(c0 + 6, 1, 8'h03);
        push(c0 + 8, 1, 8'h04);
        push(c0 + 11, 3, 8'h33);
        push(c0 + 14, 1, 8'h05);
        push(c0 + 16, 1, 8'h06);
        tick(2);
        set_word(1, 8'h02);
        tick(2);
        set_word(1, 8'h03);
        tick(2);
        set_word(1, 8'h04);
        tick(2);
        set_word(1, 8'h05);
        tick(1);
        check("burst_release_gnt", 32'(gnt), 0);
        tick(2);
        req = 4'b0010;
        tick(3);
        set_word(1, 8'h06);
        lock = '0;
        tick(2);
        req = '0;
        tick(2);

        // Lock for one word then release; next grant proves ptr=1.
        do_reset();
        c0   = cyc;
        req  = 4'b0001;
        lock = 4'b0001;
        set_word(0, 8'h22);
        push(c0 + 2, 0, 8'h22);
        push(c0 + 4, 0, 8'h33);
        push(c0 + 7, 1, 8'h55);
        push(c0 + 10, 0, 8'h44);
        tick(2);
        set_word(0, 8'h33);
        lock = '0;
        tick(2);
        check("rel_gnt_held", 32'(gnt), 32'h1);
        req = '0;
        tick(1);
        check("rel_gnt_drop", 32'(gnt), 0);
        check("rel_busy", 32'(busy), 0);
        req = 4'b0011;
        set_word(0, 8'h44);
        set_word(1, 8'h55);
        tick(2);
        req = 4'b0001;
        tick(3);
        req = '0;
        tick(2);

        // Owner 3 releases with req=1001: ptr wraps, 0 wins.
        c0  = cyc;
        req = 4'b1000;
        set_word(3, 8'h99);
        push(c0 + 2, 3, 8'h99);
        push(c0 + 5, 0, 8'h0A);
        push(c0 + 8, 3, 8'h9B);
        tick(2);
        req = 4'b1001;
        set_word(0, 8'h0A);
        set_word(3, 8'h9B);
        tick(3);
        req = 4'b1000;
        tick(3);
        req = '0;
        tick(2);

        // Async reset during the ack cycle.
        c0  = cyc;
        req = 4'b0010;
        set_word(1, 8'h5C);
        push(c0 + 2, 1, 8'h5C);
        tick(2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ack", 32'(ack), 0);
        check("arst_gnt", 32'(gnt), 0);
        check("arst_q", 32'(q), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_owner", 32'(q_owner), 0);
        tick(1);
        rst = 1'b0;
        c1  = cyc;
        req = 4'b0011;
        set_word(0, 8'h0F);
        push(c1 + 2, 0, 8'h0F);
        push(c1 + 5, 1, 8'h5C);
        tick(2);
        req = 4'b0010;
        tick(3);
        req = '0;
        tick(3);

        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
